io_out_uart_tx: RTL and testbench

Serial transmitter for the processor's 32-bit `io_out` port, the hardware-side counterpart of the simulation bench that currently watches `io_out` directly. It samples `io_out` every cycle, queues each new value in a small FIFO, and sends each queued word as four 8N1 UART bytes, least-significant byte first, on a single `tx` line. It sits beside `TOP` on the same clock, so FPGA builds can stream program output to a host.

---
 rtl/io_tx_pkg.sv | 16 +
 rtl/io_sync_fifo.sv | 57 +++++
 rtl/io_out_uart_tx.sv | 153 +++++++++++++++
 tb/tb_io_out_uart_tx.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_tx_pkg.sv
// Shared types and constants for the io_out UART transmitter.
// IO_OUT_TX_PARITY_EN adds an even-parity bit after the data bits (8E1 instead of 8N1).
package io_tx_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int DATA_BITS      = 8;

`ifdef IO_OUT_TX_PARITY_EN
    localparam int BITS_PER_BYTE = 11;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
`else
    localparam int BITS_PER_BYTE = 10;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
`endif

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with occupancy output; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module io_sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_out_uart_tx.sv
// Streams every new io_out value as four UART bytes, LSB byte first.
// Build option: IO_OUT_TX_PARITY_EN inserts an even-parity bit per byte.
module io_out_uart_tx
    import io_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [31:0]                     io_out,
    output logic                            tx,
    output logic                            busy,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    tx_state_e         state_q;
    tx_state_e         state_d;
    logic [31:0]       prev;
    logic              change;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [31:0]       fifo_dout;
    logic [BAUD_W-1:0] baud_q;
    logic              bit_end;
    logic [2:0]        bit_cnt_q;
    logic [1:0]        byte_cnt_q;
    logic [31:0]       shift_q;
`ifdef IO_OUT_TX_PARITY_EN
    logic              parity_q;
`endif

    assign change  = (io_out != prev);
    assign pop     = (state_q == IDLE) && !fifo_empty;
    assign bit_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign busy    = (state_q != IDLE);

    io_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (change),
        .pop   (pop),
        .din   (io_out),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // prev follows io_out even when the word is dropped, so a drop is never retried.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev     <= '0;
            overflow <= 1'b0;
        end else if (change) begin
            prev <= io_out;
            if (fifo_full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        tx      = 1'b1;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = START;
            end
            START: begin
                tx = 1'b0;
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                tx = shift_q[0];
                if (bit_end && bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef IO_OUT_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef IO_OUT_TX_PARITY_EN
            PARITY: begin
                tx = parity_q;
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = (byte_cnt_q < 2'(BYTES_PER_WORD - 1)) ? START : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shifting right once per data bit leaves the next byte in shift_q[7:0].
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            baud_q     <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
`ifdef IO_OUT_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            baud_q <= (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift_q    <= fifo_dout;
                        byte_cnt_q <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
`ifdef IO_OUT_TX_PARITY_EN
                        parity_q  <= 1'b0;
`endif
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q   <= {1'b0, shift_q[31:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
`ifdef IO_OUT_TX_PARITY_EN
                        parity_q  <= parity_q ^ shift_q[0];
`endif
                    end
                end
                STOP: begin
                    if (bit_end && state_d == START) byte_cnt_q <= byte_cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_out_uart_tx.sv
// Bench for io_out_uart_tx: line-level reference model, UART decoder and scoreboard.
// Honours IO_OUT_TX_PARITY_EN the same way as the design.
module tb_io_out_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef IO_OUT_TX_PARITY_EN
    localparam int BPB    = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int BPB    = 10;
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int WORD_CYC = 4 * BPB * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] io_out = '0;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    io_out_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .io_out   (io_out),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow),
        .level    (level)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Words wait in mq; a word occupies the line for WORD_CYC cycles after the
    // edge that takes it, and the next word may be taken one cycle after that.
    logic [31:0] mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] m_prev   = '0;
    logic [31:0] m_word   = '0;
    int          edge_n   = 0;
    int          m_start  = 0;
    int          m_free_at = 0;
    bit          m_active = 1'b0;
    bit          m_ovf    = 1'b0;

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                mq.delete();
                exp_q.delete();
                m_prev    = '0;
                m_free_at = 0;
                m_active  = 1'b0;
                m_ovf     = 1'b0;
            end else begin
                edge_n++;
                if (edge_n >= m_free_at && mq.size() > 0) begin
                    m_word    = mq.pop_front();
                    m_start   = edge_n;
                    m_free_at = edge_n + WORD_CYC + 1;
                    m_active  = 1'b1;
                    exp_q.push_back(m_word);
                end
                if (io_out != m_prev) begin
                    m_prev = io_out;
                    if (mq.size() < DEPTH) mq.push_back(io_out);
                    else                   m_ovf = 1'b1;
                end
            end
        end
    end

    function automatic logic exp_busy();
        return m_active && (edge_n < m_start + WORD_CYC);
    endfunction

    function automatic logic exp_tx();
        int off, bi, k;
        logic [7:0] b;
        if (!exp_busy()) return 1'b1;
        off = edge_n - m_start;
        bi  = off / (BPB * CPB);
        k   = (off % (BPB * CPB)) / CPB;
        b   = m_word[8*bi +: 8];
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && PAR_EN) return ^b;
        return 1'b1;
    endfunction

    // Cycle-by-cycle comparison of every output against the model.
    int max_level = 0;
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                check("tx", tx, exp_tx());
                check("busy", busy, exp_busy());
                check("level", level, mq.size());
                check("overflow", overflow, m_ovf);
                if (level > max_level) max_level = level;
            end
        end
    end

    // ---------------- UART decoder + scoreboard ----------------
    logic [4*BPB-1:0] dec_vals;
    logic [31:0]      last_word = '0;
    logic [3:0]       last_par  = '0;
    logic [31:0]      got_log[$];
    int               got_cnt = 0;
    int               aa_cnt  = 0;
    logic             tx_last;
    bit               glitch, aborted;

    task automatic decode_word();
        logic [31:0] w;
        logic [7:0]  d;
        bit          ok;
        w  = '0;
        ok = !glitch;
        for (int b = 0; b < 4; b++) begin
            d = dec_vals[b*BPB + 1 +: 8];
            w[8*b +: 8] = d;
            last_par[b] = dec_vals[b*BPB + 9];
            if (dec_vals[b*BPB] !== 1'b0 || dec_vals[b*BPB + BPB - 1] !== 1'b1) ok = 1'b0;
            if (PAR_EN && dec_vals[b*BPB + 9] !== ^d) ok = 1'b0;
        end
        check("frame_format", ok, 1'b1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got %0h expected none", w);
        end else begin
            check("word", w, exp_q.pop_front());
        end
        last_word = w;
        got_log.push_back(w);
        got_cnt++;
        if (w == 32'h0000_00AA) aa_cnt++;
    endtask

    initial begin
        tx_last = 1'b1;
        forever begin
            @(negedge clock);
            if (reset && tx_last && !tx) begin
                dec_vals    = '0;
                dec_vals[0] = tx;
                glitch      = 1'b0;
                aborted     = 1'b0;
                for (int i = 1; i < WORD_CYC; i++) begin
                    @(negedge clock);
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (i % CPB == 0)                  dec_vals[i/CPB] = tx;
                    else if (tx !== dec_vals[i/CPB])   glitch = 1'b1;
                end
                if (!aborted) decode_word();
            end
            tx_last = tx;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_io(input logic [31:0] v);
        @(negedge clock);
        io_out = v;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        repeat (3) @(negedge clock);
        while ((busy || level != 0 || mq.size() != 0) && t < 20000) begin
            @(negedge clock);
            t++;
        end
        repeat (2) @(negedge clock);
        check("idle_timeout", (t >= 20000), 1'b0);
    endtask

    typedef struct {
        logic [31:0] word;
        logic [7:0]  b0, b1, b2, b3;
        logic        p0;
        int          busy_len;
    } vec_t;

    vec_t vecs[5];

    // ---------------- test sequence ----------------
    initial begin
        int t, blen, gap, base_cnt;
        logic [31:0] v;

        vecs[0] = '{32'h1234_5678, 8'h78, 8'h56, 8'h34, 8'h12, 1'b0, WORD_CYC};
        vecs[1] = '{32'h0000_0001, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, WORD_CYC};
        vecs[2] = '{32'hA5C3_F00F, 8'h0F, 8'hF0, 8'hC3, 8'hA5, 1'b0, WORD_CYC};
        vecs[3] = '{32'hFFFF_FFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, WORD_CYC};
        vecs[4] = '{32'h0000_0007, 8'h07, 8'h00, 8'h00, 8'h00, 1'b1, WORD_CYC};

        // Reset held with io_out = 0: idle line, nothing ever sent.
        repeat (2) @(negedge clock);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_level", level, 3'd0);
        check("rst_overflow", overflow, 1'b0);
        #2 reset = 1'b1;
        repeat (40) @(negedge clock);
        check("no_frame_after_reset", got_cnt, 0);
        check("idle_busy", busy, 1'b0);

        // Table: one word at a time, check bytes and busy length.
        for (int i = 0; i < 5; i++) begin
            set_io(vecs[i].word);
            t = 0;
            while (!busy && t < 20) begin
                @(negedge clock);
                t++;
            end
            blen = 0;
            while (busy && blen < 2 * WORD_CYC) begin
                blen++;
                @(negedge clock);
            end
            check("vec_busy_len", blen, vecs[i].busy_len);
            check("vec_byte0", last_word[7:0],   vecs[i].b0);
            check("vec_byte1", last_word[15:8],  vecs[i].b1);
            check("vec_byte2", last_word[23:16], vecs[i].b2);
            check("vec_byte3", last_word[31:24], vecs[i].b3);
`ifdef IO_OUT_TX_PARITY_EN
            check("vec_parity0", last_par[0], vecs[i].p0);
`endif
            wait_idle();
        end

        // Two words one cycle apart: exactly one idle cycle between them.
        set_io(32'hCAFE_0001);
        set_io(32'hCAFE_0002);
        t = 0;
        while (!busy && t < 20) begin
            @(negedge clock);
            t++;
        end
        t = 0;
        while (busy && t < 2 * WORD_CYC) begin
            @(negedge clock);
            t++;
        end
        gap = 0;
        while (!busy && gap < 50) begin
            gap++;
            @(negedge clock);
        end
        check("b2b_idle_gap", gap, 1);
        wait_idle();

        // Six changes on consecutive cycles: five sent, sixth dropped.
        max_level = 0;
        base_cnt  = got_cnt;
        for (int i = 1; i <= 6; i++) set_io(32'h1111_1111 * i);
        wait_idle();
        check("ovf_set", overflow, 1'b1);
        check("ovf_level_peak", max_level, 4);
        check("ovf_words_sent", got_cnt - base_cnt, 5);
        for (int i = 0; i < 5; i++) begin
            check("ovf_order", got_log[base_cnt + i], 32'h1111_1111 * (i + 1));
        end
        repeat (20) @(negedge clock);
        check("ovf_sticky", overflow, 1'b1);

        // Random changes with random spacing.
        for (int i = 0; i < 30; i++) begin
            gap = $urandom_range(0, 60);
            repeat (gap) @(negedge clock);
            v = ($urandom_range(0, 3) == 0) ? io_out : $urandom;
            set_io(v);
        end
        wait_idle();

        // Reset during DATA of 0xAA: line idles at once, word resent once.
        set_io(32'h0);
        wait_idle();
        set_io(32'h0000_00AA);
        repeat (7) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("midreset_tx", tx, 1'b1);
        check("midreset_busy", busy, 1'b0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        aa_cnt = 0;
        wait_idle();
        check("midreset_resend_count", aa_cnt, 1);
        check("midreset_overflow_cleared", overflow, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
